exec_res_arbiter: RTL and testbench
===================================

Name: exec_res_arbiter

Overview:
- Execute-stage result collector directly downstream of the ALU logic/shift/add unit and the integer multiplier/divider.
- Arbitrates their completed results into one buffered integer-regfile write port, with a valid/ready handshake toward writeback.
- Decouples single-cycle ALU results from multi-cycle mul/div completions so writeback backpressure never drops a result.

Parameters:
- DEPTH, 2, result FIFO entries; power of 2, >= 2.
- TAGW, 4, width of the scoreboard tag carried with each write.

Ports:
- i_clk  in  1  core clock
- i_nrst  in  1  asynchronous active-low reset
- i_alu_valid  in  1  ALU result valid
- i_alu_waddr  in  6  destination register
- i_alu_wdata  in  RISCV_ARCH  ALU result
- i_alu_wtag  in  TAGW  scoreboard tag
- o_alu_ready  out  1  ALU result accepted this cycle
- i_mul_valid / i_mul_waddr / i_mul_wdata / i_mul_wtag  in  1/6/RISCV_ARCH/TAGW  multiplier result
- o_mul_ready  out  1  multiplier result accepted
- i_div_valid / i_div_waddr / i_div_wdata / i_div_wtag  in  1/6/RISCV_ARCH/TAGW  divider result
- o_div_ready  out  1  divider result accepted
- o_wena  out  1  write valid toward writeback
- o_waddr  out  6  write address
- o_wdata  out  RISCV_ARCH  write data
- o_wtag  out  TAGW  write tag
- i_wready  in  1  writeback accepts the head entry
- o_busy  out  1  FIFO non-empty or any input valid

Behaviour:
- Reset:
  - Asynchronous on i_nrst low.
  - FIFO count = 0, rd/wr pointers = 0, all entries cleared.
  - o_wena = 0, o_waddr/o_wdata/o_wtag = 0.
  - All readies reflect an empty FIFO: ready = 1 to the selected source.
- Storage:
  - DEPTH entries of {waddr, wdata, wtag}.
  - count width = $clog2(DEPTH+1).
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Arbitration, fixed priority div > mul > alu:
  - The oldest long-latency op wins; the ALU upstream stalls on o_alu_ready = 0.
  - Exactly one source is granted per cycle, and only if count < DEPTH.
  - The grant is independent of the same-cycle pop, so there is no ready-to-i_wready combinational path.
  - ready of a non-granted source = 0, even if its valid = 0.
- Accept:
  - Occurs when valid && ready.
  - If waddr == 0, the result is consumed (ready = 1) but not pushed (x0 write discarded).
  - Otherwise it is pushed at the write pointer.
- Output:
  - o_wena = (count != 0); fields = entry at the read pointer.
  - Pop occurs when o_wena && i_wready.
  - Fields must hold stable while o_wena = 1 and i_wready = 0.
- Latency: accept in cycle N -> o_wena in cycle N+1 (registered FIFO).
- Simultaneous push and pop: count unchanged, both pointers advance.
  - Allowed at count = DEPTH-1 and below.
  - At count = DEPTH, push is blocked that cycle even if a pop occurs.
- Full (count = DEPTH): all readies = 0; the multi-cycle sources hold their results.
- Empty with i_wready = 1: nothing popped, o_wena = 0.
- Tags are unchanged end to end; no reordering within the FIFO.

Optional Feature:
- Macro: EXEC_RES_ARBITER_BYPASS_EN.
- Defined:
  - When count = 0, the granted non-x0 result drives o_wena/o_waddr/o_wdata/o_wtag combinationally in the accept cycle (latency 0).
  - If i_wready = 1, it is not pushed; if i_wready = 0, it is pushed and appears from the FIFO at N+1.
- Undefined: latency is always 1 cycle via the FIFO; no input-to-output combinational path.

Test Plan:
- Reset mid-operation: 2 entries queued, i_nrst pulsed low asynchronously -> o_wena = 0 immediately; count = 0; o_alu_ready = 1 after release.
- Single ALU result: waddr = 5, wdata = 64'h1234, tag = 3, i_wready = 1 -> o_wena = 1 next cycle with the same fields; then o_wena = 0.
- Priority: alu/mul/div all valid in one cycle (waddr 1/2/3) -> grants div, then mul, then alu over 3 cycles; writes emerge in order 3, 2, 1.
- Full and backpressure: i_wready = 0, 3 ALU results offered -> two accepted, o_alu_ready = 0 on the 3rd; fields stable; i_wready = 1 then drains 2 entries, and the 3rd is accepted the cycle after count < DEPTH.
- x0 discard: ALU valid with waddr = 0, wdata = 64'hFFFF -> o_alu_ready = 1, o_wena stays 0, count stays 0.
- Wrap-around: 5 results with push/pop every cycle at count = 1 -> pointers wrap past DEPTH-1; all 5 written in order, no loss or duplication.

Source files
------------

// File: rtl/exec_res_arbiter.sv
// exec_res_arbiter: collects ALU, multiplier and divider results into one
// buffered integer-regfile write port. Fixed priority div > mul > alu, a
// DEPTH-entry result FIFO, and a valid/ready handshake toward writeback.
// Optional feature macro: EXEC_RES_ARBITER_BYPASS_EN (zero-latency bypass
// when the FIFO is empty). Default build: always one cycle through the FIFO.
module exec_res_arbiter #(
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned TAGW       = 4,
   parameter int unsigned RISCV_ARCH = 64
) (
   input  logic                  i_clk,
   input  logic                  i_nrst,
   input  logic                  i_alu_valid,
   input  logic [5:0]            i_alu_waddr,
   input  logic [RISCV_ARCH-1:0] i_alu_wdata,
   input  logic [TAGW-1:0]       i_alu_wtag,
   output logic                  o_alu_ready,
   input  logic                  i_mul_valid,
   input  logic [5:0]            i_mul_waddr,
   input  logic [RISCV_ARCH-1:0] i_mul_wdata,
   input  logic [TAGW-1:0]       i_mul_wtag,
   output logic                  o_mul_ready,
   input  logic                  i_div_valid,
   input  logic [5:0]            i_div_waddr,
   input  logic [RISCV_ARCH-1:0] i_div_wdata,
   input  logic [TAGW-1:0]       i_div_wtag,
   output logic                  o_div_ready,
   output logic                  o_wena,
   output logic [5:0]            o_waddr,
   output logic [RISCV_ARCH-1:0] o_wdata,
   output logic [TAGW-1:0]       o_wtag,
   input  logic                  i_wready,
   output logic                  o_busy
);

   localparam int unsigned CNTW = $clog2(DEPTH + 1);
   localparam int unsigned PTRW = $clog2(DEPTH);

   typedef struct packed {
      logic [5:0]            waddr;
      logic [RISCV_ARCH-1:0] wdata;
      logic [TAGW-1:0]       wtag;
   } entry_t;

   entry_t          mem_q [DEPTH];
   entry_t          mem_d [DEPTH];
   logic [CNTW-1:0] count_q, count_d;
   logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;

   logic   room;
   logic   sel_valid;
   entry_t sel;
   logic   acc_nz;
   logic   push;
   logic   pop;
   logic   fifo_nempty;
   entry_t head;

   // Grant selection: div > mul > alu, gated only by FIFO occupancy (never by the pop)
   always_comb begin
      room        = (count_q < CNTW'(DEPTH));
      sel         = '{waddr: i_alu_waddr, wdata: i_alu_wdata, wtag: i_alu_wtag};
      sel_valid   = i_alu_valid;
      o_div_ready = 1'b0;
      o_mul_ready = 1'b0;
      o_alu_ready = 1'b0;
      if (i_div_valid) begin
         sel         = '{waddr: i_div_waddr, wdata: i_div_wdata, wtag: i_div_wtag};
         sel_valid   = 1'b1;
         o_div_ready = room;
      end else if (i_mul_valid) begin
         sel         = '{waddr: i_mul_waddr, wdata: i_mul_wdata, wtag: i_mul_wtag};
         sel_valid   = 1'b1;
         o_mul_ready = room;
      end else begin
         o_alu_ready = room;
      end
      // x0 writes are consumed but never stored
      acc_nz = room && sel_valid && (sel.waddr != 6'd0);
   end

   assign fifo_nempty = (count_q != '0);
   assign head        = mem_q[rd_ptr_q];
   assign pop         = fifo_nempty && i_wready;
   assign o_busy      = fifo_nempty || i_alu_valid || i_mul_valid || i_div_valid;

`ifdef EXEC_RES_ARBITER_BYPASS_EN
   logic byp;

   // Empty FIFO: the accepted result drives the write port directly; store it only if stalled
   always_comb begin
      byp     = acc_nz && !fifo_nempty;
      push    = acc_nz && !(byp && i_wready);
      o_wena  = fifo_nempty || byp;
      o_waddr = byp ? sel.waddr : head.waddr;
      o_wdata = byp ? sel.wdata : head.wdata;
      o_wtag  = byp ? sel.wtag  : head.wtag;
   end
`else
   // Write port is always the FIFO head; one cycle of latency, no input-to-output path
   always_comb begin
      push    = acc_nz;
      o_wena  = fifo_nempty;
      o_waddr = head.waddr;
      o_wdata = head.wdata;
      o_wtag  = head.wtag;
   end
`endif

   // FIFO next state: push at write pointer, pop at read pointer, pointers wrap mod DEPTH
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = sel;
         wr_ptr_d        = wr_ptr_q + PTRW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTRW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNTW'(1);
         2'b01:   count_d = count_q - CNTW'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO state registers
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: tb/tb_exec_res_arbiter.sv
// Randomised and directed bench for exec_res_arbiter (default build, DEPTH=2).
module tb_exec_res_arbiter;

   localparam int unsigned DEPTH = 2;
   localparam int unsigned TAGW  = 4;
   localparam int unsigned XLEN  = 64;

   logic            i_clk = 1'b0;
   logic            i_nrst;
   logic            i_alu_valid, i_mul_valid, i_div_valid;
   logic [5:0]      i_alu_waddr, i_mul_waddr, i_div_waddr;
   logic [XLEN-1:0] i_alu_wdata, i_mul_wdata, i_div_wdata;
   logic [TAGW-1:0] i_alu_wtag, i_mul_wtag, i_div_wtag;
   logic            o_alu_ready, o_mul_ready, o_div_ready;
   logic            o_wena;
   logic [5:0]      o_waddr;
   logic [XLEN-1:0] o_wdata;
   logic [TAGW-1:0] o_wtag;
   logic            i_wready;
   logic            o_busy;

   int total = 0;
   int bad   = 0;

   exec_res_arbiter #(.DEPTH(DEPTH), .TAGW(TAGW), .RISCV_ARCH(XLEN)) dut (
      .i_clk(i_clk), .i_nrst(i_nrst),
      .i_alu_valid(i_alu_valid), .i_alu_waddr(i_alu_waddr), .i_alu_wdata(i_alu_wdata),
      .i_alu_wtag(i_alu_wtag), .o_alu_ready(o_alu_ready),
      .i_mul_valid(i_mul_valid), .i_mul_waddr(i_mul_waddr), .i_mul_wdata(i_mul_wdata),
      .i_mul_wtag(i_mul_wtag), .o_mul_ready(o_mul_ready),
      .i_div_valid(i_div_valid), .i_div_waddr(i_div_waddr), .i_div_wdata(i_div_wdata),
      .i_div_wtag(i_div_wtag), .o_div_ready(o_div_ready),
      .o_wena(o_wena), .o_waddr(o_waddr), .o_wdata(o_wdata), .o_wtag(o_wtag),
      .i_wready(i_wready), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: an ordered list of pending writes, at most DEPTH long
   typedef struct {
      logic [5:0]      a;
      logic [XLEN-1:0] d;
      logic [TAGW-1:0] t;
   } wr_t;

   wr_t mq[$];
   wr_t nw;
   int  n;
   bit  room, popm;

   // Per-cycle comparison against the model, then advance the model over the coming edge
   always @(negedge i_clk) begin
      if (!i_nrst) mq.delete();
      n    = mq.size();
      room = (n < int'(DEPTH));
      check("div_ready", 64'(o_div_ready), 64'(room && i_div_valid));
      check("mul_ready", 64'(o_mul_ready), 64'(room && !i_div_valid && i_mul_valid));
      check("alu_ready", 64'(o_alu_ready), 64'(room && !i_div_valid && !i_mul_valid));
      check("wena", 64'(o_wena), 64'(n != 0));
      check("busy", 64'(o_busy), 64'((n != 0) || i_alu_valid || i_mul_valid || i_div_valid));
      if (n != 0) begin
         check("waddr", 64'(o_waddr), 64'(mq[0].a));
         check("wdata", o_wdata, mq[0].d);
         check("wtag", 64'(o_wtag), 64'(mq[0].t));
      end
      if (i_nrst) begin
         popm = (n != 0) && i_wready;
         nw.a = 6'd0;
         if (room) begin
            if (i_div_valid)      nw = '{i_div_waddr, i_div_wdata, i_div_wtag};
            else if (i_mul_valid) nw = '{i_mul_waddr, i_mul_wdata, i_mul_wtag};
            else if (i_alu_valid) nw = '{i_alu_waddr, i_alu_wdata, i_alu_wtag};
         end
         if (popm) void'(mq.pop_front());
         if (nw.a != 6'd0) mq.push_back(nw);
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle();
      i_alu_valid = 0; i_alu_waddr = 0; i_alu_wdata = 0; i_alu_wtag = 0;
      i_mul_valid = 0; i_mul_waddr = 0; i_mul_wdata = 0; i_mul_wtag = 0;
      i_div_valid = 0; i_div_waddr = 0; i_div_wdata = 0; i_div_wtag = 0;
      i_wready    = 1;
   endtask

   task automatic alu(input logic v, input logic [5:0] a, input logic [63:0] d, input logic [3:0] t);
      i_alu_valid = v; i_alu_waddr = a; i_alu_wdata = d; i_alu_wtag = t;
   endtask

   function automatic logic [5:0] rnd_addr();
      if ($urandom_range(0, 7) == 0) return 6'd0;
      return 6'($urandom_range(1, 63));
   endfunction

   bit acc_a, acc_m, acc_d;

   initial begin
      i_nrst = 0;
      idle();
      repeat (2) tick();
      // Reset state
      @(negedge i_clk);
      check("rst_wena", 64'(o_wena), 64'd0);
      check("rst_waddr", 64'(o_waddr), 64'd0);
      check("rst_wdata", o_wdata, 64'd0);
      check("rst_wtag", 64'(o_wtag), 64'd0);
      check("rst_alu_ready", 64'(o_alu_ready), 64'd1);
      check("rst_mul_ready", 64'(o_mul_ready), 64'd0);
      @(posedge i_clk); #3 i_nrst = 1;
      tick();

      // Single ALU result
      alu(1, 6'd5, 64'h1234, 4'd3);
      @(negedge i_clk);
      check("single_ready", 64'(o_alu_ready), 64'd1);
      check("single_lat0", 64'(o_wena), 64'd0);
      tick(); alu(0, 0, 0, 0);
      @(negedge i_clk);
      check("single_wena", 64'(o_wena), 64'd1);
      check("single_waddr", 64'(o_waddr), 64'd5);
      check("single_wdata", o_wdata, 64'h1234);
      check("single_wtag", 64'(o_wtag), 64'd3);
      tick();
      @(negedge i_clk);
      check("single_done", 64'(o_wena), 64'd0);
      tick();

      // Priority div > mul > alu
      alu(1, 6'd1, 64'h11, 4'd1);
      i_mul_valid = 1; i_mul_waddr = 6'd2; i_mul_wdata = 64'h22; i_mul_wtag = 4'd2;
      i_div_valid = 1; i_div_waddr = 6'd3; i_div_wdata = 64'h33; i_div_wtag = 4'd4;
      @(negedge i_clk);
      check("prio_div_rdy", 64'(o_div_ready), 64'd1);
      check("prio_mul_rdy0", 64'(o_mul_ready), 64'd0);
      check("prio_alu_rdy0", 64'(o_alu_ready), 64'd0);
      tick(); i_div_valid = 0;
      @(negedge i_clk);
      check("prio_mul_rdy", 64'(o_mul_ready), 64'd1);
      check("prio_out1", 64'(o_waddr), 64'd3);
      tick(); i_mul_valid = 0;
      @(negedge i_clk);
      check("prio_alu_rdy", 64'(o_alu_ready), 64'd1);
      check("prio_out2", 64'(o_waddr), 64'd2);
      tick(); alu(0, 0, 0, 0);
      @(negedge i_clk);
      check("prio_out3", 64'(o_waddr), 64'd1);
      tick();

      // Full and backpressure
      i_wready = 0;
      alu(1, 6'd7, 64'h70, 4'd7);
      tick(); alu(1, 6'd8, 64'h80, 4'd8);
      tick(); alu(1, 6'd9, 64'h90, 4'd9);
      @(negedge i_clk);
      check("full_block", 64'(o_alu_ready), 64'd0);
      tick();
      @(negedge i_clk);
      check("full_hold_rdy", 64'(o_alu_ready), 64'd0);
      check("full_stable", 64'(o_waddr), 64'd7);
      tick(); i_wready = 1;
      @(negedge i_clk);
      check("full_pop_nogrant", 64'(o_alu_ready), 64'd0);
      tick();
      @(negedge i_clk);
      check("full_regrant", 64'(o_alu_ready), 64'd1);
      check("full_out8", 64'(o_waddr), 64'd8);
      tick(); alu(0, 0, 0, 0);
      @(negedge i_clk);
      check("full_out9", 64'(o_waddr), 64'd9);
      tick();

      // x0 discard
      alu(1, 6'd0, 64'hFFFF, 4'd1);
      @(negedge i_clk);
      check("x0_ready", 64'(o_alu_ready), 64'd1);
      tick(); alu(0, 0, 0, 0);
      @(negedge i_clk);
      check("x0_wena", 64'(o_wena), 64'd0);
      check("x0_busy", 64'(o_busy), 64'd0);
      tick();

      // Wrap-around: push and pop every cycle
      for (int i = 0; i < 5; i++) begin
         alu(1, 6'(10 + i), 64'(100 + i), 4'(i));
         @(negedge i_clk);
         check("wrap_ready", 64'(o_alu_ready), 64'd1);
         if (i > 0) check("wrap_out", 64'(o_waddr), 64'(10 + i - 1));
         tick();
      end
      alu(0, 0, 0, 0);
      @(negedge i_clk);
      check("wrap_last", 64'(o_waddr), 64'd14);
      tick();
      @(negedge i_clk);
      check("wrap_empty", 64'(o_wena), 64'd0);
      tick();

      // Reset mid-operation
      i_wready = 0;
      alu(1, 6'd20, 64'h20, 4'd2);
      tick(); alu(1, 6'd21, 64'h21, 4'd3);
      tick(); alu(0, 0, 0, 0);
      @(negedge i_clk);
      check("mid_wena_pre", 64'(o_wena), 64'd1);
      @(posedge i_clk); #3 i_nrst = 0;
      #1 check("mid_wena_rst", 64'(o_wena), 64'd0);
      @(posedge i_clk); #3 i_nrst = 1;
      @(negedge i_clk);
      check("mid_alu_ready", 64'(o_alu_ready), 64'd1);
      check("mid_wena_post", 64'(o_wena), 64'd0);
      tick();

      // Randomised traffic; sources hold a result until it is accepted
      acc_a = 0; acc_m = 0; acc_d = 0;
      for (int c = 0; c < 800; c++) begin
         if (!i_alu_valid || acc_a) begin
            i_alu_valid = ($urandom_range(0, 9) < 6);
            i_alu_waddr = rnd_addr(); i_alu_wdata = {$urandom, $urandom}; i_alu_wtag = 4'($urandom);
         end
         if (!i_mul_valid || acc_m) begin
            i_mul_valid = ($urandom_range(0, 9) < 2);
            i_mul_waddr = rnd_addr(); i_mul_wdata = {$urandom, $urandom}; i_mul_wtag = 4'($urandom);
         end
         if (!i_div_valid || acc_d) begin
            i_div_valid = ($urandom_range(0, 9) < 1);
            i_div_waddr = rnd_addr(); i_div_wdata = {$urandom, $urandom}; i_div_wtag = 4'($urandom);
         end
         i_wready = ($urandom_range(0, 9) < 7);
         @(negedge i_clk);
         acc_a = i_alu_valid && o_alu_ready;
         acc_m = i_mul_valid && o_mul_ready;
         acc_d = i_div_valid && o_div_ready;
         tick();
      end
      idle();
      repeat (4) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
